lustre_unsigned_cmp_seq: RTL

- Multi-cycle unsigned comparator. Compares two N-bit operands through one W-bit internal_lustre_adder slice, using K = ceil(N/W) passes, LSB chunk first.
- Each pass computes lhs_chunk + ~rhs_chunk + carry and chains the carry between passes.
- Used when a wide unsigned `<` / `=` in generated code would otherwise need a long combinational carry chain.
- Operands are accepted and results returned over valid/ready handshakes.

---
 rtl/lustre_unsigned_cmp_seq_pkg.sv | 21 ++
 rtl/lustre_unsigned_cmp_seq_adder.sv | 28 ++
 rtl/lustre_unsigned_cmp_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/lustre_unsigned_cmp_seq_pkg.sv
// Shared definitions for the multi-cycle unsigned comparator: FSM state
// encoding and the sizing helpers used for chunk count and index width.
package lustre_unsigned_cmp_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Integer ceiling division, used to size the number of adder passes.
   function automatic int ceil_div(input int num, input int den);
      return (num + den - 32'sd1) / den;
   endfunction

   // Width of the chunk index register; never narrower than one bit.
   function automatic int idx_width(input int k);
      return (k > 32'sd1) ? $clog2(k) : 32'sd1;
   endfunction

endpackage

// File: rtl/lustre_unsigned_cmp_seq_adder.sv
// Single W-bit adder slice with condition flags. The comparator feeds it
// one operand chunk per cycle and chains the carry externally.
module internal_lustre_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         carry_in,
   output logic [N-1:0] res,
   output logic         flag_C,
   output logic         flag_Z,
   output logic         flag_N,
   output logic         flag_V
);

   logic [N:0] sum_s;

   // Add with carry-in and derive carry, zero, sign and signed-overflow flags.
   always_comb begin
      sum_s  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, carry_in};
      res    = sum_s[N-1:0];
      flag_C = sum_s[N];
      flag_Z = (sum_s[N-1:0] == {N{1'b0}});
      flag_N = sum_s[N-1];
      flag_V = (a[N-1] == b[N-1]) && (sum_s[N-1] != a[N-1]);
   end

endmodule

// File: rtl/lustre_unsigned_cmp_seq.sv
// Multi-cycle unsigned comparator: lhs is compared with rhs by running
// lhs + ~rhs + 1 through one W-bit adder slice, LSB chunk first. The final
// carry gives lhs >= rhs; an all-zero sum across every chunk gives equality.
module lustre_unsigned_cmp_seq
   import lustre_unsigned_cmp_seq_pkg::*;
#(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [N-1:0] lhs,
   input  logic [N-1:0] rhs,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         res_lt,
   output logic         res_eq
);

   localparam int K  = ceil_div(N, W);
   localparam int KW = K * W;
   localparam int IW = idx_width(K);

   state_t          state_r;
   logic [KW-1:0]   lhs_r;
   logic [KW-1:0]   rhs_r;
   logic [IW-1:0]   idx_r;
   logic            carry_r;
   logic            zacc_r;
   logic            start_ready_r;
   logic            res_valid_r;
   logic            res_lt_r;
   logic            res_eq_r;

   logic [W-1:0]    lhs_chunk_s;
   logic [W-1:0]    rhs_inv_s;
   logic            flag_c_s;
   logic            flag_z_s;
   logic            last_chunk_s;

   // Select the current chunk of each operand; rhs is inverted for subtraction.
   always_comb begin
      lhs_chunk_s  = lhs_r[int'(idx_r) * W +: W];
      rhs_inv_s    = ~rhs_r[int'(idx_r) * W +: W];
      last_chunk_s = (idx_r == IW'(K - 1));
   end

   internal_lustre_adder #(.N(W)) u_adder (
      .a        (lhs_chunk_s),
      .b        (rhs_inv_s),
      .carry_in (carry_r),
      .res      (),
      .flag_C   (flag_c_s),
      .flag_Z   (flag_z_s),
      .flag_N   (),
      .flag_V   ()
   );

   // Control FSM with operand capture, carry/zero chaining and result latch.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r       <= IDLE;
         lhs_r         <= {KW{1'b0}};
         rhs_r         <= {KW{1'b0}};
         idx_r         <= {IW{1'b0}};
         carry_r       <= 1'b0;
         zacc_r        <= 1'b0;
         start_ready_r <= 1'b1;
         res_valid_r   <= 1'b0;
         res_lt_r      <= 1'b0;
         res_eq_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_valid && start_ready_r) begin
                  // Zero-extension pads both operands identically above N.
                  lhs_r         <= KW'(lhs);
                  rhs_r         <= KW'(rhs);
                  idx_r         <= {IW{1'b0}};
                  carry_r       <= 1'b1;
                  zacc_r        <= 1'b1;
                  start_ready_r <= 1'b0;
                  state_r       <= RUN;
               end else begin
                  state_r       <= IDLE;
               end
            end
            RUN: begin
               carry_r <= flag_c_s;
               zacc_r  <= zacc_r & flag_z_s;
               idx_r   <= idx_r + IW'(1);
               if (last_chunk_s) begin
                  res_lt_r    <= ~flag_c_s;
                  res_eq_r    <= zacc_r & flag_z_s;
                  res_valid_r <= 1'b1;
                  state_r     <= DONE;
               end else begin
                  state_r     <= RUN;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid_r   <= 1'b0;
                  start_ready_r <= 1'b1;
                  state_r       <= IDLE;
               end else begin
                  state_r       <= DONE;
               end
            end
            default: begin
               res_valid_r   <= 1'b0;
               start_ready_r <= 1'b1;
               state_r       <= IDLE;
            end
         endcase
      end
   end

   assign start_ready = start_ready_r;
   assign res_valid   = res_valid_r;
   assign res_lt      = res_lt_r;
   assign res_eq      = res_eq_r;

endmodule
